// File: rtl/mul64x64t128_pkg.sv
// Shared math constants and product types for the NTT datapath.
// The 128-bit product type is the bus handed to the Goldilocks reducer.
package mul64x64t128_pkg;

    localparam int PIPE_DEPTH_MUL64X64 = 4;

    typedef logic [63:0]  u64_t;
    typedef logic [127:0] prod128_t;

endpackage

// File: rtl/mul64x64t128_mul32x32.sv
// Unsigned 32x32 -> 64 multiplier, one ce-gated register of latency.
// NO_DSP picks an inferred fabric multiply or a DSP-shaped split.
module mul32x32 #(
    parameter bit NO_DSP = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ce_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [63:0] p_o
);

    generate
        if (NO_DSP) begin : g_fabric
            logic [63:0] r_p;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_p <= '0;
                end else if (ce_i) begin
                    r_p <= 64'(a_i) * 64'(b_i);
                end
            end

            assign p_o = r_p;
        end else begin : g_dsp
            // Low 17 bits of b feed the first slice, the rest cascades in
            // shifted by 17; only the post-add is registered (PREG-style).
            logic [48:0] w_lo;
            logic [46:0] w_hi;
            (* use_dsp = "yes" *) logic [63:0] r_p;

            assign w_lo = 49'(a_i) * 49'(b_i[16:0]);
            assign w_hi = 47'(a_i) * 47'(b_i[31:17]);

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_p <= '0;
                end else if (ce_i) begin
                    r_p <= 64'(w_lo) + {w_hi, 17'b0};
                end
            end

            assign p_o = r_p;
        end
    endgenerate

endmodule

// File: rtl/mul64x64t128.sv
// Pipelined 64x64 -> 128 unsigned multiplier, fixed 4-cycle latency.
// Feeds the Goldilocks reducer; valid travels alongside the data.
module mul64x64t128
    import mul64x64t128_pkg::*;
#(
    parameter bit NO_DSP     = 1'b1,
    parameter int PIPE_DEPTH = PIPE_DEPTH_MUL64X64
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         ce_i,
    input  logic         valid_i,
    input  logic [63:0]  a_i,
    input  logic [63:0]  b_i,
    output logic         valid_o,
    output logic [127:0] p_o
);

    generate
        if (PIPE_DEPTH != PIPE_DEPTH_MUL64X64) begin : g_bad_depth
            $error("mul64x64t128: PIPE_DEPTH is fixed at 4");
        end
    endgenerate

    u64_t     r_a;
    u64_t     r_b;
    logic     r_v1;
    logic     r_v2;
    logic     r_v3;
    logic     r_v4;
    logic [63:0] w_ll;
    logic [63:0] w_lh;
    logic [63:0] w_hl;
    logic [63:0] w_hh;
    logic [64:0] r_mid;
    logic [63:0] r_lo;
    logic [63:0] r_hi;
    prod128_t r_p;
    prod128_t w_sum;

    // S1: operand capture
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_a  <= '0;
            r_b  <= '0;
            r_v1 <= 1'b0;
        end else if (ce_i) begin
            r_a  <= a_i;
            r_b  <= b_i;
            r_v1 <= valid_i;
        end
    end

    // S2: four partial products, registered inside mul32x32
    mul32x32 #(.NO_DSP(NO_DSP)) u_ll (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .ce_i  (ce_i),
        .a_i   (r_a[31:0]),
        .b_i   (r_b[31:0]),
        .p_o   (w_ll)
    );

    mul32x32 #(.NO_DSP(NO_DSP)) u_lh (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .ce_i  (ce_i),
        .a_i   (r_a[31:0]),
        .b_i   (r_b[63:32]),
        .p_o   (w_lh)
    );

    mul32x32 #(.NO_DSP(NO_DSP)) u_hl (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .ce_i  (ce_i),
        .a_i   (r_a[63:32]),
        .b_i   (r_b[31:0]),
        .p_o   (w_hl)
    );

    mul32x32 #(.NO_DSP(NO_DSP)) u_hh (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .ce_i  (ce_i),
        .a_i   (r_a[63:32]),
        .b_i   (r_b[63:32]),
        .p_o   (w_hh)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_v2 <= 1'b0;
        end else if (ce_i) begin
            r_v2 <= r_v1;
        end
    end

    // S3: cross terms summed with the carry kept in bit 64
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_mid <= '0;
            r_lo  <= '0;
            r_hi  <= '0;
            r_v3  <= 1'b0;
        end else if (ce_i) begin
            r_mid <= {1'b0, w_lh} + {1'b0, w_hl};
            r_lo  <= w_ll;
            r_hi  <= w_hh;
            r_v3  <= r_v2;
        end
    end

    assign w_sum = {r_hi, r_lo} + {31'b0, r_mid, 32'b0};

    // S4: final combine; outputs come straight from these flops
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_p  <= '0;
            r_v4 <= 1'b0;
        end else if (ce_i) begin
            r_p  <= w_sum;
            r_v4 <= r_v3;
        end
    end

    assign p_o     = r_p;
    assign valid_o = r_v4;

endmodule

// File: tb/tb_mul64x64t128.sv
// Self-checking bench for mul64x64t128: latency vectors, random stream
// with ce/valid toggling, and mid-stream reset.
module tb_mul64x64t128;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         ce_i = 1'b0;
    logic         valid_i = 1'b0;
    logic [63:0]  a_i = '0;
    logic [63:0]  b_i = '0;
    logic         valid_o;
    logic [127:0] p_o;

    int checks = 0;
    int errors = 0;
    int n_in = 0;
    int n_out = 0;

    logic [127:0] sb[$];
    logic         ce_seen = 1'b0;
    logic [127:0] last_p = '0;
    logic         last_v = 1'b0;

    localparam logic [127:0] GOLD = 128'hFFFFFFFF00000001;

    typedef struct {
        logic [63:0]  a;
        logic [63:0]  b;
        logic [127:0] p;
        string        name;
    } vec_t;

    vec_t vecs[6];

    mul64x64t128 dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .ce_i    (ce_i),
        .valid_i (valid_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .valid_o (valid_o),
        .p_o     (p_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [127:0] model(input logic [63:0] a, b);
        logic [127:0] x;
        logic [127:0] y;
        x = {64'b0, a};
        y = {64'b0, b};
        return x * y;
    endfunction

    task automatic chk(input string nm, input logic [127:0] got, exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic drive(input logic ce, v, input logic [63:0] a, b);
        ce_i = ce;
        valid_i = v;
        a_i = a;
        b_i = b;
        @(posedge clk_i);
        #1;
    endtask

    // Issue one pair and verify it surfaces exactly 4 ce cycles later
    task automatic run_one(input logic [63:0] a, b,
                           input logic [127:0] exp, input string nm);
        drive(1'b1, 1'b1, a, b);
        for (int k = 1; k <= 3; k++) begin
            chk({nm, "_early_valid"}, {127'b0, valid_o}, 128'd0);
            drive(1'b1, 1'b0, 64'd0, 64'd0);
        end
        chk({nm, "_valid"}, {127'b0, valid_o}, 128'd1);
        chk(nm, p_o, exp);
    endtask

    // Scoreboard producer: one entry per accepted valid pair
    always @(posedge clk_i) begin
        if (!rst_i) begin
            ce_seen = ce_i;
            if (ce_i && valid_i) begin
                sb.push_back(model(a_i, b_i));
                n_in++;
            end
        end else begin
            ce_seen = 1'b0;
        end
    end

    always @(posedge rst_i) begin
        n_in -= sb.size();
        sb.delete();
    end

    // Scoreboard consumer and hold check for ce_i=0 cycles
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (ce_seen) begin
                if (valid_o) begin
                    if (sb.size() == 0) begin
                        chk("sb_unexpected_valid", 128'd1, 128'd0);
                    end else begin
                        chk("sb_product", p_o, sb.pop_front());
                        n_out++;
                    end
                end
            end else begin
                chk("hold_p", p_o, last_p);
                chk("hold_v", {127'b0, valid_o}, {127'b0, last_v});
            end
            last_p = p_o;
            last_v = valid_o;
        end else begin
            last_p = '0;
            last_v = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{64'h0, 64'h0, 128'h0, "zero"};
        vecs[1] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF,
                    128'hFFFFFFFFFFFFFFFE_0000000000000001, "all_ones"};
        vecs[2] = '{64'h00000000FFFFFFFF, 64'h0000000100000000,
                    128'h0000000000000000_FFFFFFFF00000000, "lo_x_2p32"};
        vecs[3] = '{64'h0000000100000000, 64'h0000000100000000,
                    128'h0000000000000001_0000000000000000, "2p32_sq"};
        vecs[4] = '{64'hFFFFFFFF00000000, 64'hFFFFFFFF00000000,
                    128'hFFFFFFFE00000001_0000000000000000, "gold_pm1_sq"};
        vecs[5] = '{64'h123456789ABCDEF0, 64'h2,
                    128'h0000000000000000_2468ACF13579BDE0, "times_two"};

        repeat (3) @(posedge clk_i);
        #1;
        chk("reset_valid", {127'b0, valid_o}, 128'd0);
        chk("reset_p", p_o, 128'd0);
        rst_i = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_one(vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].name);
            if (i == 4) begin
                chk("gold_reduce", p_o % GOLD, 128'd1);
            end
        end

        // Reset with a valid output present and three more in flight
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 64'(i + 3), 64'(i + 7));
        end
        chk("pre_reset_valid", {127'b0, valid_o}, 128'd1);
        rst_i = 1'b1;
        #1;
        chk("rst_valid_now", {127'b0, valid_o}, 128'd0);
        chk("rst_p_now", p_o, 128'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, 64'd0, 64'd0);
            chk("no_stale_valid", {127'b0, valid_o}, 128'd0);
        end
        run_one(64'hDEADBEEFCAFEF00D, 64'h0123456789ABCDEF,
                model(64'hDEADBEEFCAFEF00D, 64'h0123456789ABCDEF),
                "post_reset");

        // Random stream, ce low ~30% of cycles
        for (int i = 0; i < 1000; i++) begin
            logic [63:0] a;
            logic [63:0] b;
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if ($urandom_range(0, 9) == 0) a = '1;
            if ($urandom_range(0, 9) == 0) b = '1;
            drive($urandom_range(0, 9) >= 3, 1'($urandom_range(0, 1)), a, b);
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 64'd0, 64'd0);
        end
        @(negedge clk_i);

        chk("sb_drained", 128'(sb.size()), 128'd0);
        chk("valid_count", 128'(n_out), 128'(n_in));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
